tile_stream_manager: RTL and testbench

Parametrised streamer that reads a square IMG_DIM x IMG_DIM input image from single-port vector memory as non-overlapping TILE x TILE tiles in raster order. It presents the last NUM_LANES tiles side by side to the MAC lanes: the newest tile goes live from memory and the older ones replay from per-lane caches. It sits between vector memory and the MAC array and adds valid/ready back-pressure and a per-lane valid mask.

---
 rtl/tile_stream_manager.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_tile_stream_manager.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tile_stream_manager.sv
// tile_stream_manager
//   Streams a square IMG_DIM x IMG_DIM image out of single-port vector memory
//   as non-overlapping TILE x TILE tiles in raster order. The newest tile goes
//   live on its lane straight from memory. The other NUM_LANES-1 lanes replay
//   the previous tiles from per-lane caches. Beats pass through a 2-entry skid
//   buffer with valid/ready handshake.
//
//   Optional feature macro: TILE_STREAM_WRAP_EN. When defined, the tile
//   counter wraps after the last tile and streaming never ends, so done
//   stays 0. When undefined, the block drains and then raises done.
//
// Ports
//   clock, clear          : clock; synchronous active-high reset
//   en                    : run enable; 0 pauses issue, state held
//   mem_rdata             : read data, valid one cycle after mem_enable
//   mem_addr, mem_enable  : registered read address / strobe
//   mem_write             : tied 0
//   out_ready, out_valid  : beat handshake
//   out_data              : lane j at [j*DATA_W +: DATA_W]
//   out_lane_valid        : lanes holding a loaded tile
//   out_elem_index        : element index inside the tile
//   out_tile_index        : tile currently live
//   out_last_elem         : beat is the last element of its tile
//   done                  : all tiles streamed

// One lane: tile cache plus the mux between live data and replay.
module tile_stream_lane #(
  parameter int DATA_W = 16,
  parameter int NE     = 9,
  parameter int EW     = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              i_live,
  input  logic              i_last,
  input  logic [EW-1:0]     i_elem,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_data,
  output logic              o_cached
);
  logic [DATA_W-1:0] r_cache [NE];
  logic              r_cached;

  // Cache contents survive clear; only the valid bit is reset.
  always_ff @(posedge clock)
    if (!clear && i_live) r_cache[i_elem] <= i_wdata;

  always_ff @(posedge clock) begin
    if (clear)                 r_cached <= 1'b0;
    else if (i_live && i_last) r_cached <= 1'b1;
  end

  assign o_data   = i_live ? i_wdata : (r_cached ? r_cache[i_elem] : '0);
  assign o_cached = r_cached;
endmodule

module tile_stream_manager #(
  parameter int DATA_W    = 16,
  parameter int IMG_DIM   = 12,
  parameter int TILE      = 3,
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = 9
) (
  input  logic                                               clock,
  input  logic                                               clear,
  input  logic                                               en,
  input  logic [DATA_W-1:0]                                  mem_rdata,
  output logic [ADDR_W-1:0]                                  mem_addr,
  output logic                                               mem_enable,
  output logic                                               mem_write,
  input  logic                                               out_ready,
  output logic                                               out_valid,
  output logic [NUM_LANES*DATA_W-1:0]                        out_data,
  output logic [NUM_LANES-1:0]                               out_lane_valid,
  output logic [$clog2(TILE*TILE)-1:0]                       out_elem_index,
  output logic [$clog2((IMG_DIM/TILE)*(IMG_DIM/TILE))-1:0]   out_tile_index,
  output logic                                               out_last_elem,
  output logic                                               done
);
  localparam int TPR = IMG_DIM / TILE;
  localparam int T   = TPR * TPR;
  localparam int NE  = TILE * TILE;
  localparam int EW  = $clog2(NE);
  localparam int TW  = $clog2(T);
  localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CW  = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int PW  = (TPR > 1) ? $clog2(TPR) : 1;

  localparam logic [EW-1:0]     LAST_E    = EW'(NE - 1);
  localparam logic [TW-1:0]     LAST_T    = TW'(T - 1);
  localparam logic [CW-1:0]     LAST_C    = CW'(TILE - 1);
  localparam logic [PW-1:0]     LAST_TC   = PW'(TPR - 1);
  localparam logic [LW-1:0]     LAST_L    = LW'(NUM_LANES - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_DIM);
  localparam logic [ADDR_W-1:0] TILE_STEP = ADDR_W'(TILE);
  localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'(TILE * IMG_DIM);

`ifdef TILE_STREAM_WRAP_EN
  localparam bit STOP_AT_END = 1'b0;
`else
  localparam bit STOP_AT_END = 1'b1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [NUM_LANES*DATA_W-1:0] data;
    logic [NUM_LANES-1:0]        mask;
    logic [EW-1:0]               elem;
    logic [TW-1:0]               tile;
    logic                        last;
  } beat_t;

  state_t r_state, w_state_nxt;

  // Issue-side address generation: nested counters plus base accumulators.
  logic [CW-1:0]     r_ec, r_er;
  logic [EW-1:0]     r_e;
  logic [PW-1:0]     r_tc;
  logic [TW-1:0]     r_t;
  logic [LW-1:0]     r_lane;
  logic [ADDR_W-1:0] r_row_base, r_tile_base, r_band_base, r_mem_addr;

  // [0]: read on the memory port, [1]: its data on mem_rdata.
  logic [1:0]        r_vld_pipe;
  logic [EW-1:0]     r_m0_elem, r_m1_elem;
  logic [TW-1:0]     r_m0_tile, r_m1_tile;
  logic [LW-1:0]     r_m0_lane, r_m1_lane;
  logic              r_m0_last, r_m1_last;

  beat_t             r_buf [2];
  logic              r_wp, r_rp;
  logic [1:0]        r_cnt;

  logic [ADDR_W-1:0]                   w_addr;
  logic [2:0]                          w_load;
  logic                                w_issue, w_end_elem, w_end_tile;
  logic                                w_push, w_pop;
  logic [NUM_LANES-1:0][DATA_W-1:0]    w_lane_data;
  logic [NUM_LANES-1:0]                w_cached, w_mask;
  beat_t                               w_beat, w_head;

  assign w_addr     = r_row_base + ADDR_W'(r_ec);
  assign w_end_elem = (r_e == LAST_E);
  assign w_end_tile = w_end_elem && (r_t == LAST_T);
  // Buffered beats plus reads still in flight never exceed the 2 skid slots.
  assign w_load     = 3'(r_cnt) + 3'(r_vld_pipe[0]) + 3'(r_vld_pipe[1]);
  assign w_issue    = (r_state == S_RUN) && en && (w_load < 3'd2);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_ec        <= '0;
      r_er        <= '0;
      r_e         <= '0;
      r_tc        <= '0;
      r_t         <= '0;
      r_lane      <= '0;
      r_row_base  <= '0;
      r_tile_base <= '0;
      r_band_base <= '0;
      r_mem_addr  <= '0;
      r_vld_pipe  <= '0;
      r_m0_elem   <= '0;
      r_m0_tile   <= '0;
      r_m0_lane   <= '0;
      r_m0_last   <= 1'b0;
      r_m1_elem   <= '0;
      r_m1_tile   <= '0;
      r_m1_lane   <= '0;
      r_m1_last   <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], w_issue};
      r_m1_elem  <= r_m0_elem;
      r_m1_tile  <= r_m0_tile;
      r_m1_lane  <= r_m0_lane;
      r_m1_last  <= r_m0_last;
      if (w_issue) begin
        r_mem_addr <= w_addr;
        r_m0_elem  <= r_e;
        r_m0_tile  <= r_t;
        r_m0_lane  <= r_lane;
        r_m0_last  <= w_end_elem;
        r_e        <= w_end_elem ? '0 : r_e + 1'b1;
        if (r_ec != LAST_C) begin
          r_ec <= r_ec + 1'b1;
        end else begin
          r_ec <= '0;
          if (r_er != LAST_C) begin
            r_er       <= r_er + 1'b1;
            r_row_base <= r_row_base + ROW_STEP;
          end else begin
            r_er   <= '0;
            r_lane <= (r_lane == LAST_L) ? '0 : r_lane + 1'b1;
            if (r_t == LAST_T) begin
              // Back to tile 0; only reused when wrapping is enabled.
              r_t         <= '0;
              r_tc        <= '0;
              r_band_base <= '0;
              r_tile_base <= '0;
              r_row_base  <= '0;
            end else if (r_tc != LAST_TC) begin
              r_t         <= r_t + 1'b1;
              r_tc        <= r_tc + 1'b1;
              r_tile_base <= r_tile_base + TILE_STEP;
              r_row_base  <= r_tile_base + TILE_STEP;
            end else begin
              r_t         <= r_t + 1'b1;
              r_tc        <= '0;
              r_band_base <= r_band_base + BAND_STEP;
              r_tile_base <= r_band_base + BAND_STEP;
              r_row_base  <= r_band_base + BAND_STEP;
            end
          end
        end
      end
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_enable = r_vld_pipe[0];
  assign mem_write  = 1'b0;

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    logic w_live_lane;
    assign w_live_lane = (r_m1_lane == LW'(j));
    tile_stream_lane #(.DATA_W(DATA_W), .NE(NE), .EW(EW)) u_lane (
      .clock    (clock),
      .clear    (clear),
      .i_live   (r_vld_pipe[1] && w_live_lane),
      .i_last   (r_m1_last),
      .i_elem   (r_m1_elem),
      .i_wdata  (mem_rdata),
      .o_data   (w_lane_data[j]),
      .o_cached (w_cached[j])
    );
    assign w_mask[j] = w_cached[j] | w_live_lane;
  end

  always_comb begin
    w_beat      = '0;
    w_beat.data = w_lane_data;
    w_beat.mask = w_mask;
    w_beat.elem = r_m1_elem;
    w_beat.tile = r_m1_tile;
    w_beat.last = r_m1_last;
  end

  // Skid buffer: 2-entry FIFO, head presented on out_*.
  assign w_push = r_vld_pipe[1];
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clock)
    if (!clear && w_push) r_buf[r_wp] <= w_beat;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  assign w_head         = r_buf[r_rp];
  assign out_valid      = (r_cnt != 2'd0);
  assign out_data       = out_valid ? w_head.data : '0;
  assign out_lane_valid = out_valid ? w_head.mask : '0;
  assign out_elem_index = out_valid ? w_head.elem : '0;
  assign out_tile_index = out_valid ? w_head.tile : '0;
  assign out_last_elem  = out_valid && w_head.last;

  always_ff @(posedge clock) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_RUN;
      S_RUN:   if (STOP_AT_END && w_issue && w_end_tile) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_cnt == 2'd0 && r_vld_pipe == 2'b00) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign done = (r_state == S_DONE);
endmodule

// File: tb/tb_tile_stream_manager.sv
module tb_tile_stream_manager;
  localparam int DW = 16, IMG = 12, TL = 3, NL = 4, AW = 9;
  localparam int TPR = IMG / TL, NT = TPR * TPR, NE = TL * TL;
  localparam int NB = NT * NE;  // 144 beats per pass

  logic          clock, clear, en, out_ready;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_enable, mem_write, out_valid, out_last_elem, done;
  logic [NL*DW-1:0] out_data;
  logic [NL-1:0] out_lane_valid;
  logic [3:0]    out_elem_index, out_tile_index;

  tile_stream_manager dut (
    .clock(clock), .clear(clear), .en(en), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_write(mem_write),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_lane_valid(out_lane_valid), .out_elem_index(out_elem_index),
    .out_tile_index(out_tile_index), .out_last_elem(out_last_elem), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory word = address, one cycle read latency.
  always @(posedge clock) if (mem_enable) mem_rdata <= DW'(mem_addr);

  int n_tests = 0, n_fail = 0, nrec = 0;
  logic [63:0] rec_data [200];
  logic [3:0]  rec_mask [200], rec_elem [200], rec_tile [200];
  logic        rec_last [200];
  logic [63:0] ref_data [NB];
  logic [3:0]  ref_mask [NB], ref_elem [NB], ref_tile [NB];
  logic        ref_last [NB];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  // Record a beat that transfers at the coming edge, then advance.
  task automatic tick();
    if (out_valid && out_ready && nrec < 200) begin
      rec_data[nrec] = out_data;       rec_mask[nrec] = out_lane_valid;
      rec_elem[nrec] = out_elem_index; rec_tile[nrec] = out_tile_index;
      rec_last[nrec] = out_last_elem;  nrec++;
    end
    cyc();
  endtask

  task automatic run_to(input int n, input string tag);
    int g = 0;
    while (nrec < n && g < 3000) begin tick(); g++; end
    check(tag, 64'(nrec), 64'(n));
  endtask

  task automatic latency(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin cyc(); lat++; end
    check(tag, 64'(lat), 64'd4);
  endtask

  function automatic int ea(int t, int e);
    return ((t / TPR) * TL + e / TL) * IMG + (t % TPR) * TL + e % TL;
  endfunction

  function automatic logic [63:0] exp_data(int t, int e);
    logic [63:0] d = '0;
    for (int j = 0; j < NL; j++) begin
      int tj = t - ((t % NL - j + NL) % NL);
      if (tj >= 0) d[j*DW +: DW] = DW'(ea(tj, e));
    end
    return d;
  endfunction

  function automatic logic [3:0] exp_mask(int t);
    logic [3:0] m = '0;
    for (int j = 0; j < NL; j++)
      if (t - ((t % NL - j + NL) % NL) >= 0) m[j] = 1'b1;
    return m;
  endfunction

  function automatic int ref_diffs(int n);
    int bad = 0;
    for (int k = 0; k < n; k++)
      if (rec_data[k] !== ref_data[k] || rec_mask[k] !== ref_mask[k] ||
          rec_elem[k] !== ref_elem[k] || rec_tile[k] !== ref_tile[k] ||
          rec_last[k] !== ref_last[k]) bad++;
    return bad;
  endfunction

  task automatic restart();
    clear = 1'b1; en = 1'b0; cyc(); clear = 1'b0; nrec = 0; en = 1'b1;
  endtask

  initial begin
    logic [77:0] snap;
    logic        held;
    int          stall_bad, stalls, g;

    clear = 1'b1; en = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    // Reset state
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_misc", 64'({out_lane_valid, out_elem_index, out_tile_index, out_last_elem,
                           mem_enable, mem_addr, mem_write, done}), 64'd0);
    clear = 1'b0; cyc(); cyc();
    check("idle_no_issue", 64'({mem_enable, out_valid}), 64'd0);

    // Unstalled reference pass
    en = 1'b1;
    latency("first_latency");
    run_to(NB, "ref_count");
    for (int k = 0; k < NB; k++) begin
      check($sformatf("ref_data[%0d]", k), rec_data[k], exp_data(k / NE, k % NE));
      check($sformatf("ref_meta[%0d]", k),
            64'({rec_mask[k], rec_elem[k], rec_tile[k], rec_last[k]}),
            64'({exp_mask(k / NE), 4'(k % NE), 4'(k / NE), (k % NE) == NE - 1}));
      ref_data[k] = rec_data[k]; ref_mask[k] = rec_mask[k]; ref_elem[k] = rec_elem[k];
      ref_tile[k] = rec_tile[k]; ref_last[k] = rec_last[k];
    end
    check("t0e0_lane0", 64'(rec_data[0][15:0]), 64'd0);
    check("t0e0_mask", 64'(rec_mask[0]), 64'h1);
    check("t0e0_elem", 64'(rec_elem[0]), 64'd0);
    check("t0e4_lane0", 64'(rec_data[4][15:0]), 64'd13);
    check("t1e4_data", rec_data[13], 64'h0000_0000_0010_000D);
    check("t1e4_mask", 64'(rec_mask[13]), 64'h3);
    check("t4e0_data", rec_data[36], 64'h0009_0006_0003_0024);
    check("t4e0_mask", 64'(rec_mask[36]), 64'hF);

`ifdef TILE_STREAM_WRAP_EN
    run_to(NB + 1, "wrap_count");
    check("wrap_lane0", 64'(rec_data[NB][15:0]), 64'd0);
    check("wrap_meta", 64'({rec_mask[NB], rec_elem[NB], rec_tile[NB]}), 64'h0F00);
    check("wrap_done", 64'(done), 64'd0);
`else
    g = 0;
    while (!done && g < 30) begin tick(); g++; end
    check("end_done", 64'(done), 64'd1);
    check("end_mem_enable", 64'(mem_enable), 64'd0);
    check("end_no_extra", 64'(nrec), 64'(NB));
`endif

    // Random back-pressure: same stream, outputs frozen while stalled
    restart();
    held = 1'b0; snap = '0; stall_bad = 0; stalls = 0; g = 0;
    while (nrec < NB && g < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (held && {out_valid, out_data, out_lane_valid, out_elem_index, out_tile_index,
                   out_last_elem} !== snap) stall_bad++;
      held = out_valid && !out_ready;
      if (held) stalls++;
      snap = {out_valid, out_data, out_lane_valid, out_elem_index, out_tile_index, out_last_elem};
      tick(); g++;
    end
    out_ready = 1'b1;
    check("bp_count", 64'(nrec), 64'(NB));
    check("bp_stream_diffs", 64'(ref_diffs(NB)), 64'd0);
    check("bp_stall_unstable", 64'(stall_bad), 64'd0);
    check("bp_saw_stalls", 64'(stalls > 0), 64'd1);

    // Pause mid tile 2 for 5 cycles, then resume
    restart();
    run_to(21, "pause_pre_count");
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("pause_mem_enable[%0d]", i), 64'(mem_enable), 64'd0);
    end
    en = 1'b1;
    run_to(NB, "pause_count");
    check("pause_stream_diffs", 64'(ref_diffs(NB)), 64'd0);

    // Clear after 50 beats, then restart from the first tile
    restart();
    run_to(50, "mid_count");
    clear = 1'b1; cyc();
    check("clr_valid_data", 64'(out_valid) | out_data, 64'd0);
    check("clr_misc", 64'({out_lane_valid, out_elem_index, out_tile_index, out_last_elem,
                           mem_enable, mem_addr, done}), 64'd0);
    clear = 1'b0; nrec = 0;
    latency("restart_latency");
    run_to(NE + 1, "restart_count");
    check("restart_diffs", 64'(ref_diffs(NE + 1)), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
